// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder on the far side of the MEM-stage RAM request port.
// It services one read or write per request from an internal word array
// after WAIT_CYCLES busy cycles. It also asks CTRL to stall while the access
// is still running, so the EX/MEM register holds the request steady.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   ram_we     write request (wins over ram_re when both are high)
//   ram_re     read request
//   ram_addr   byte address, word index taken from [ADDR_WIDTH+1:2]
//   ram_sel    byte-lane enables for writes
//   ram_wdata  lane-aligned store data
//   ram_rdata  registered read data, held until the next read completes
//   stall_req  combinational stall request to CTRL
//   ram_ack    one-cycle completion pulse
//   addr_err   one-cycle pulse alongside ram_ack for out-of-range accesses

module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ram_we,
   input  logic        ram_re,
   input  logic [31:0] ram_addr,
   input  logic [3:0]  ram_sel,
   input  logic [31:0] ram_wdata,
   output logic [31:0] ram_rdata,
   output logic        stall_req,
   output logic        ram_ack,
   output logic        addr_err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [3:0] LOAD_VAL = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   state_t state;
   state_t next_state;
   logic [3:0] count;
   logic [3:0] count_next;
   logic is_write_q;
   logic op_write;
   logic req;
   logic enter_done;
   logic out_of_range;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic unused_addr_bits;
   logic [31:0] mem [0:DEPTH-1];

   assign req              = ram_we | ram_re;
   assign word_idx         = ram_addr[ADDR_WIDTH+1:2];
   assign out_of_range     = (ram_addr >> (ADDR_WIDTH + 2)) != 32'd0;
   assign unused_addr_bits = ^ram_addr[1:0];

   // The access type is fixed when the request is accepted. If the request
   // is flushed during BUSY, the FSM still finishes the access it started and
   // does not take a new type from the now-idle inputs. With zero wait states
   // the accept and completion edges are the same edge, so the live input is
   // used in that case.
   assign op_write   = (state == IDLE) ? ram_we : is_write_q;
   assign enter_done = (next_state == DONE);
   assign stall_req  = req & (state != DONE);

   // Next-state and wait counter. The counter is loaded with WAIT_CYCLES-1
   // on accept, so BUSY lasts exactly WAIT_CYCLES cycles before DONE.
   always_comb begin
      next_state = state;
      count_next = count;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES > 0) begin
                  next_state = BUSY;
                  count_next = LOAD_VAL;
               end else begin
                  next_state = DONE;
               end
            end
         end
         BUSY: begin
            if (count == 4'd0) begin
               next_state = DONE;
            end else begin
               count_next = count - 4'd1;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register, counter and latched access type. Reset drops any
   // access in flight, so an aborted write never reaches the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= 4'd0;
         is_write_q <= 1'b0;
      end else begin
         state <= next_state;
         count <= count_next;
         if (state == IDLE && req) begin
            is_write_q <= ram_we;
         end
      end
   end

   // The word array has no reset. A write updates only the selected lanes,
   // and only on the edge that enters DONE. Out-of-range writes are dropped
   // so they cannot alias onto a low word.
   always_ff @(posedge clk) begin
      if (enter_done && op_write && !out_of_range) begin
         for (int k = 0; k < 4; k++) begin
            if (ram_sel[k]) begin
               mem[word_idx][8*k +: 8] <= ram_wdata[8*k +: 8];
            end
         end
      end
   end

   // Completion flags are registered, so they are high only during DONE.
   // Read data is loaded only by reads, so writes leave the last read value
   // visible to the MEM stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_rdata <= 32'd0;
         ram_ack   <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         ram_ack  <= enter_done;
         addr_err <= enter_done & out_of_range;
         if (enter_done && !op_write) begin
            ram_rdata <= out_of_range ? 32'd0 : mem[word_idx];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Scoreboard bench for dmem_responder. Instance A uses two wait states and
// instance B uses zero wait states; the two share clock and reset.
// Stimulus pushes the hand-computed response into a per-instance queue. A
// monitor pops the queue and compares whenever the matching instance acks.

module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        a_we, a_re, a_stall, a_ack, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic [3:0]  a_sel;

   logic        b_we, b_re, b_stall, b_ack, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [3:0]  b_sel;

   exp_t qA[$];
   exp_t qB[$];
   exp_t eA;
   exp_t eB;

   int total;
   int bad;
   int abortAcks;

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dutA (
      .clk(clk), .rst_n(rst_n),
      .ram_we(a_we), .ram_re(a_re), .ram_addr(a_addr), .ram_sel(a_sel),
      .ram_wdata(a_wdata), .ram_rdata(a_rdata), .stall_req(a_stall),
      .ram_ack(a_ack), .addr_err(a_err)
   );

   dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dutB (
      .clk(clk), .rst_n(rst_n),
      .ram_we(b_we), .ram_re(b_re), .ram_addr(b_addr), .ram_sel(b_sel),
      .ram_wdata(b_wdata), .ram_rdata(b_rdata), .stall_req(b_stall),
      .ram_ack(b_ack), .addr_err(b_err)
   );

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point. Every check updates the counters here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one instance's request inputs.
   task automatic driveInputs(input int dut, input logic we, input logic re,
                              input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wdata);
      if (dut == 0) begin
         a_we = we; a_re = re; a_addr = addr; a_sel = sel; a_wdata = wdata;
      end else begin
         b_we = we; b_re = re; b_addr = addr; b_sel = sel; b_wdata = wdata;
      end
   endtask

   // Issues one request. The caller must be just after a rising edge. The
   // task queues the expected response and holds the request until the
   // access completes. It also checks stall length and ack latency, then
   // returns just after the edge that ends DONE so the next request can
   // follow immediately.
   task automatic applyStimulus(input int dut, input logic we, input logic re,
                                input logic [31:0] addr, input logic [3:0] sel,
                                input logic [31:0] wdata, input logic [31:0] expRdata,
                                input logic expErr, input string name);
      exp_t e;
      int waitc;
      int stalls;
      int cycles;
      logic acked;
      waitc = (dut == 0) ? 2 : 0;
      e.rdata = expRdata;
      e.err = expErr;
      e.name = name;
      if (dut == 0) qA.push_back(e); else qB.push_back(e);
      driveInputs(dut, we, re, addr, sel, wdata);
      stalls = 0;
      cycles = 0;
      acked = 1'b0;
      while (!acked && cycles < 40) begin
         @(negedge clk);
         cycles++;
         if ((dut == 0) ? a_ack : b_ack) acked = 1'b1;
         else if ((dut == 0) ? a_stall : b_stall) stalls++;
      end
      checkOutput({name, " ack seen"}, {31'd0, acked}, 32'd1);
      if (acked) begin
         checkOutput({name, " ack latency"}, 32'(cycles), 32'(waitc + 2));
         checkOutput({name, " stall cycles"}, 32'(stalls), 32'(waitc + 1));
      end
      @(posedge clk);
      #1;
      driveInputs(dut, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
   endtask

   // Monitor: on every ack, pop the expected response and compare it.
   // stall_req must already be low in the completion cycle.
   always @(negedge clk) begin
      if (a_ack) begin
         if (qA.size() == 0) begin
            checkOutput("A unexpected ack", {31'd0, a_ack}, 32'd0);
         end else begin
            eA = qA.pop_front();
            checkOutput({eA.name, " rdata"}, a_rdata, eA.rdata);
            checkOutput({eA.name, " addr_err"}, {31'd0, a_err}, {31'd0, eA.err});
            checkOutput({eA.name, " stall in done"}, {31'd0, a_stall}, 32'd0);
         end
      end
      if (b_ack) begin
         if (qB.size() == 0) begin
            checkOutput("B unexpected ack", {31'd0, b_ack}, 32'd0);
         end else begin
            eB = qB.pop_front();
            checkOutput({eB.name, " rdata"}, b_rdata, eB.rdata);
            checkOutput({eB.name, " addr_err"}, {31'd0, b_err}, {31'd0, eB.err});
            checkOutput({eB.name, " stall in done"}, {31'd0, b_stall}, 32'd0);
         end
      end
   end

   // Directed sequence.
   initial begin
      total = 0;
      bad = 0;
      abortAcks = 0;
      rst_n = 1'b0;
      driveInputs(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      driveInputs(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset A rdata", a_rdata, 32'd0);
      checkOutput("reset A ack", {31'd0, a_ack}, 32'd0);
      checkOutput("reset A addr_err", {31'd0, a_err}, 32'd0);
      checkOutput("reset B rdata", b_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("idle A stall", {31'd0, a_stall}, 32'd0);
      checkOutput("idle B stall", {31'd0, b_stall}, 32'd0);
      @(posedge clk);
      #1;

      $display("[TB] instance A, two wait states");
      applyStimulus(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0, "A wr 0x10");
      applyStimulus(0, 0, 1, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0, "A rd 0x10");
      applyStimulus(0, 1, 0, 32'h20, 4'hF, 32'h11223344, 32'hDEADBEEF, 0, "A wr 0x20 full");
      applyStimulus(0, 1, 0, 32'h20, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF, 0, "A wr 0x20 sel0101");
      applyStimulus(0, 0, 1, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 0, "A rd 0x20 partial");
      applyStimulus(0, 1, 0, 32'h0, 4'hF, 32'h0BADF00D, 32'h11BB33DD, 0, "A wr 0x0");
      applyStimulus(0, 0, 1, 32'h0001_0000, 4'hF, 32'h0, 32'h0, 1, "A rd out-of-range");
      applyStimulus(0, 1, 0, 32'h0001_0000, 4'hF, 32'hFFFFFFFF, 32'h0, 1, "A wr out-of-range");
      applyStimulus(0, 0, 1, 32'h0, 4'hF, 32'h0, 32'h0BADF00D, 0, "A rd 0x0 after oor");
      applyStimulus(0, 0, 1, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0, "A rd 0x10 again");
      applyStimulus(0, 1, 1, 32'h8, 4'hF, 32'h55AA55AA, 32'hDEADBEEF, 0, "A we+re 0x8");
      applyStimulus(0, 0, 1, 32'h8, 4'hF, 32'h0, 32'h55AA55AA, 0, "A rd 0x8");
      applyStimulus(0, 1, 0, 32'h10, 4'h0, 32'h0, 32'h55AA55AA, 0, "A wr sel0");
      applyStimulus(0, 0, 1, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0, "A rd 0x10 after sel0");
      applyStimulus(0, 1, 0, 32'h40, 4'hF, 32'hCAFEF00D, 32'hDEADBEEF, 0, "A wr 0x40");

      $display("[TB] instance B, zero wait states, back-to-back");
      applyStimulus(1, 1, 0, 32'h100, 4'hF, 32'h01020304, 32'h0, 0, "B wr 0x100");
      applyStimulus(1, 1, 0, 32'h104, 4'hF, 32'hA5A5A5A5, 32'h0, 0, "B wr 0x104");
      applyStimulus(1, 0, 1, 32'h100, 4'hF, 32'h0, 32'h01020304, 0, "B rd A");
      applyStimulus(1, 0, 1, 32'h104, 4'hF, 32'h0, 32'hA5A5A5A5, 0, "B rd B");
      applyStimulus(1, 1, 0, 32'h108, 4'hF, 32'h0F0F0F0F, 32'hA5A5A5A5, 0, "B wr C");
      applyStimulus(1, 0, 1, 32'h108, 4'hF, 32'h0, 32'h0F0F0F0F, 0, "B rd C");
      applyStimulus(1, 0, 1, 32'h104, 4'hF, 32'h0, 32'hA5A5A5A5, 0, "B rd B again");

      $display("[TB] reset during a busy write");
      driveInputs(0, 1'b1, 1'b0, 32'h40, 4'hF, 32'h12345678);
      @(negedge clk);
      checkOutput("abort stall first cycle", {31'd0, a_stall}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort A rdata", a_rdata, 32'd0);
      checkOutput("abort A ack", {31'd0, a_ack}, 32'd0);
      checkOutput("abort A addr_err", {31'd0, a_err}, 32'd0);
      checkOutput("abort B rdata", b_rdata, 32'd0);
      driveInputs(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (a_ack) abortAcks++;
      end
      checkOutput("abort no ack", 32'(abortAcks), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 1, 32'h40, 4'hF, 32'h0, 32'hCAFEF00D, 0, "A rd 0x40 after abort");

      repeat (3) @(posedge clk);
      checkOutput("A queue drained", 32'(qA.size()), 32'd0);
      checkOutput("B queue drained", 32'(qB.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
